// File: rtl/ret_stack.sv
// Hardware return-address stack: CALL pushes PC+1, RET pops the top into the PC.
// Top of stack is visible combinationally so RET loads the PC with no extra latency.
module ret_stack #(
   parameter int unsigned N     = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [N-1:0]  din_i,
   input  logic          err_clr_i,
   output logic [N-1:0]  dout_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o,
   output logic          ovf_o,
   output logic          unf_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [N-1:0]  mem_q [DEPTH];
   logic [CW-1:0] sp_q, sp_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic          is_empty, is_full;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == CW'(DEPTH));

   // Next-state decode; an error event is applied after the clear so it wins.
   always_comb begin
      sp_d   = sp_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      wr_en  = 1'b0;
      wr_idx = '0;
      if (err_clr_i) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      unique case ({push_i, pop_i})
         2'b10: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               wr_en  = 1'b1;
               wr_idx = AW'(sp_q);
               sp_d   = sp_q + CW'(1);
            end
         end
         2'b01: begin
            if (is_empty) unf_d = 1'b1;
            else          sp_d  = sp_q - CW'(1);
         end
         2'b11: begin
            // Replace top in place; from empty the pop underflows but the push lands.
            wr_en = 1'b1;
            if (is_empty) begin
               unf_d  = 1'b1;
               wr_idx = '0;
               sp_d   = CW'(1);
            end else begin
               wr_idx = AW'(sp_q - CW'(1));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Entry storage is not reset; SP alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en && !rst_i) mem_q[wr_idx] <= din_i;
   end

   assign dout_o  = is_empty ? '0 : mem_q[AW'(sp_q - CW'(1))];
   assign empty_o = is_empty;
   assign full_o  = is_full;
   assign count_o = sp_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Bench for ret_stack: directed scenarios then random traffic, checked against a
// queue-based model of a bounded LIFO with sticky overflow/underflow flags.
module tb_ret_stack;

   localparam int unsigned N     = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          push_i = 1'b0;
   logic          pop_i = 1'b0;
   logic [N-1:0]  din_i = '0;
   logic          err_clr_i = 1'b0;
   logic [N-1:0]  dout_o;
   logic          empty_o;
   logic          full_o;
   logic [CW-1:0] count_o;
   logic          ovf_o;
   logic          unf_o;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] model_q [$];
   logic         m_ovf = 1'b0;
   logic         m_unf = 1'b0;

   ret_stack #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_i     (rst_i),
      .push_i    (push_i),
      .pop_i     (pop_i),
      .din_i     (din_i),
      .err_clr_i (err_clr_i),
      .dout_o    (dout_o),
      .empty_o   (empty_o),
      .full_o    (full_o),
      .count_o   (count_o),
      .ovf_o     (ovf_o),
      .unf_o     (unf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned  sz;
      logic [N-1:0] top;
      sz  = model_q.size();
      top = (sz == 0) ? '0 : model_q[sz-1];
      check({tag, ".count"}, 32'(count_o), 32'(sz));
      check({tag, ".empty"}, 32'(empty_o), 32'(sz == 0));
      check({tag, ".full"},  32'(full_o),  32'(sz == DEPTH));
      check({tag, ".dout"},  32'(dout_o),  32'(top));
      check({tag, ".ovf"},   32'(ovf_o),   32'(m_ovf));
      check({tag, ".unf"},   32'(unf_o),   32'(m_unf));
   endtask

   // Reference behaviour of one clock edge.
   task automatic model_edge(input logic p, input logic q, input logic [N-1:0] d,
                             input logic c, input logic r);
      if (r) begin
         model_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         return;
      end
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && q) begin
         if (model_q.size() == 0) begin
            m_unf = 1'b1;
            model_q.push_back(d);
         end else begin
            model_q[model_q.size()-1] = d;
         end
      end else if (p) begin
         if (model_q.size() == DEPTH) m_ovf = 1'b1;
         else                         model_q.push_back(d);
      end else if (q) begin
         if (model_q.size() == 0) m_unf = 1'b1;
         else                     void'(model_q.pop_back());
      end
   endtask

   task automatic step(input string tag, input logic p, input logic q,
                       input logic [N-1:0] d, input logic c, input logic r);
      @(negedge clk);
      push_i    = p;
      pop_i     = q;
      din_i     = d;
      err_clr_i = c;
      rst_i     = r;
      @(posedge clk);
      model_edge(p, q, d, c, r);
      #1;
      check_all(tag);
   endtask

   initial begin
      int unsigned r;
      logic        p, q, c, rs;

      step("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      step("push12", 1'b1, 1'b0, 8'h12, 1'b0, 1'b0);

      step("rst_fill", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, N'(i), 1'b0, 1'b0);
      step("push_full", 1'b1, 1'b0, 8'h09, 1'b0, 1'b0);
      step("err_clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step("ovf_vs_clr", 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
      step("pushpop_full", 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);

      step("rst_lifo", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step("lifo_p1", 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
      step("lifo_p2", 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
      step("lifo_p3", 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("lifo_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      step("unf_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step("unf_pushpop", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);

      step("rst_repl", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step("repl_p1", 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
      step("repl_p2", 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
      step("repl_pp", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      step("repl_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      step("rst_mid", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) step("mid_fill", 1'b1, 1'b0, N'(8'h60 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("mid_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step("rst_dom", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
      step("rst_dom2", 1'b1, 1'b0, 8'hEF, 1'b0, 1'b1);
      step("post_rst_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 99);
         rs = (r < 2);
         c  = ($urandom_range(0, 99) < 8);
         p  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 35));
         q  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 60));
         step("rand", p, q, N'($urandom), c, rs);
      end

      @(negedge clk);
      push_i    = 1'b0;
      pop_i     = 1'b0;
      err_clr_i = 1'b0;
      rst_i     = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
